// File: rtl/rs_syndrome_hankel_if.sv
// Stream-in / matrix-out bundle for the syndrome + Hankel stage.
// The master side drives codeword symbols and consumes the matrix; the slave side is the block.
interface rs_syndrome_hankel_if;
  logic [7:0] in_sym;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] d1, d2, d3, d4, d5, d6, d7, d8, d9;
  logic [7:0] rhs1, rhs2, rhs3;
  logic       syn_zero;
  logic       len_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_sym, in_valid, in_last, out_ready,
    input  in_ready, d1, d2, d3, d4, d5, d6, d7, d8, d9,
           rhs1, rhs2, rhs3, syn_zero, len_err, out_valid
  );

  modport slave (
    input  in_sym, in_valid, in_last, out_ready,
    output in_ready, d1, d2, d3, d4, d5, d6, d7, d8, d9,
           rhs1, rhs2, rhs3, syn_zero, len_err, out_valid
  );
endinterface

// File: rtl/rs_syndrome_hankel.sv
// Horner-rule syndrome accumulator (S1..S6, GF(2^8), poly 0x11D) presenting the
// 3x3 Hankel matrix and right-hand column to the determinant stage.
//
// state | meaning
// IDLE  | waiting for the first symbol of a codeword
// ACCUM | mid-codeword, folding symbols into S1..S6
// HOLD  | result presented until out_ready
module rs_syndrome_hankel #(
  parameter int N_SYM = 15,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  rs_syndrome_hankel_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SYM);

  state_t           state_q, state_d;
  logic [7:0]       syn_q [6];
  logic [7:0]       syn_scaled [6];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] cnt_next;
  logic             len_err_q;
  logic             accept;
  logic             cnt_hit;
  logic             block_end;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
  endfunction

  // S_j is scaled by alpha^j: j chained xtime stages, unrolled at elaboration.
  always_comb begin
    for (int j = 0; j < 6; j++) begin
      syn_scaled[j] = syn_q[j];
      for (int i = 0; i < 6; i++) begin
        if (i <= j) syn_scaled[j] = xtime(syn_scaled[j]);
      end
    end
  end

  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    cnt_next  = (state_q == IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
    cnt_hit   = (cnt_next == N_LAST);
    block_end = accept && (bus.in_last || cnt_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = block_end ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (block_end) state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 6; j++) syn_q[j] <= 8'h00;
      count_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (accept) begin
        // The first symbol restarts the accumulators rather than folding old results in.
        for (int j = 0; j < 6; j++) begin
          syn_q[j] <= (state_q == IDLE) ? bus.in_sym : (syn_scaled[j] ^ bus.in_sym);
        end
        count_q <= cnt_next;
        if (block_end) len_err_q <= bus.in_last ^ cnt_hit;
      end
      if (state_q == HOLD && bus.out_ready) begin
        count_q   <= '0;
        len_err_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.len_err   = len_err_q;

  assign bus.d1 = syn_q[0];
  assign bus.d2 = syn_q[1];
  assign bus.d3 = syn_q[2];
  assign bus.d4 = syn_q[1];
  assign bus.d5 = syn_q[2];
  assign bus.d6 = syn_q[3];
  assign bus.d7 = syn_q[2];
  assign bus.d8 = syn_q[3];
  assign bus.d9 = syn_q[4];

  assign bus.rhs1 = syn_q[3];
  assign bus.rhs2 = syn_q[4];
  assign bus.rhs3 = syn_q[5];

  assign bus.syn_zero = ~|{syn_q[0], syn_q[1], syn_q[2], syn_q[3], syn_q[4], syn_q[5]};

endmodule

// File: tb/tb_rs_syndrome_hankel.sv
// Bench for rs_syndrome_hankel: per-scenario tasks plus a scoreboard monitor that
// pops the model's expected syndromes on every completed output handshake.
module tb_rs_syndrome_hankel;
  localparam int N_SYM = 15;

  typedef struct packed {
    logic [5:0][7:0] s;
    logic            zero;
    logic            len_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs_syndrome_hankel_if bus();

  rs_syndrome_hankel #(.N_SYM(N_SYM), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t       sb_q[$];
  logic [7:0] stim_sym[$];
  logic       stim_last[$];
  int         errors = 0;
  int         checks = 0;
  bit         done = 1'b0;
  exp_t       mon_e;
  logic [95:0] dut_mat;

  assign dut_mat = {bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6, bus.d7, bus.d8, bus.d9,
                    bus.rhs1, bus.rhs2, bus.rhs3};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
    end
    return r;
  endfunction

  function automatic logic [95:0] mat_of(input exp_t e);
    return {e.s[0], e.s[1], e.s[2], e.s[1], e.s[2], e.s[3], e.s[2], e.s[3], e.s[4],
            e.s[3], e.s[4], e.s[5]};
  endfunction

  // Reference: Horner evaluation at alpha^1..alpha^6 over the stimulus, ending at the
  // first in_last or at the N_SYM-th symbol.
  function automatic exp_t model();
    exp_t       e;
    logic [7:0] apow [6];
    logic [7:0] p;
    int         cnt = 0;
    e = '0;
    for (int j = 0; j < 6; j++) begin
      p = 8'h01;
      for (int k = 0; k <= j; k++) p = gf_mul(p, 8'h02);
      apow[j] = p;
    end
    for (int i = 0; i < stim_sym.size(); i++) begin
      for (int j = 0; j < 6; j++) e.s[j] = gf_mul(e.s[j], apow[j]) ^ stim_sym[i];
      cnt++;
      if (stim_last[i] || cnt == N_SYM) begin
        e.len_err = stim_last[i] ^ (cnt == N_SYM);
        break;
      end
    end
    e.zero = (e.s == '0);
    return e;
  endfunction

  task automatic stim_clear();
    stim_sym.delete();
    stim_last.delete();
  endtask

  task automatic stim_add(input logic [7:0] sym, input logic last);
    stim_sym.push_back(sym);
    stim_last.push_back(last);
  endtask

  task automatic stim_random(input int len, input bit with_last);
    stim_clear();
    for (int i = 0; i < len; i++) stim_add(8'($urandom_range(0, 255)), with_last && (i == len - 1));
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic drive_block();
    sb_q.push_back(model());
    for (int i = 0; i < stim_sym.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_sym   = stim_sym[i];
      bus.in_last  = stim_last[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid=%b after final accept, expected 1", bus.out_valid);
    end
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 20; k++) begin
      if (sb_q.size() == 0 && bus.out_valid !== 1'b1) break;
      @(posedge clk); #1;
    end
    checks++;
    if (k == 20) begin
      errors++;
      $display("FAIL drain: timeout, pending=%0d out_valid=%b, expected 0 pending", sb_q.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_sym = 8'h00; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got=%b exp=0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got=%b exp=1", bus.in_ready); end
    if (dut_mat !== 96'h0) begin errors++; $display("FAIL reset_matrix: got=%h exp=0", dut_mat); end
    if (bus.syn_zero !== 1'b1) begin errors++; $display("FAIL reset_syn_zero: got=%b exp=1", bus.syn_zero); end
    if (bus.len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got=%b exp=0", bus.len_err); end
  endtask

  task automatic test_zero_block();
    stim_clear();
    for (int i = 0; i < N_SYM; i++) stim_add(8'h00, i == N_SYM - 1);
    drive_block();
    checks += 2;
    if (bus.syn_zero !== 1'b1) begin errors++; $display("FAIL zero_syn_zero: got=%b exp=1", bus.syn_zero); end
    if (dut_mat !== 96'h0) begin errors++; $display("FAIL zero_matrix: got=%h exp=0", dut_mat); end
    wait_drain();
  endtask

  task automatic test_impulse_deg0();
    stim_clear();
    for (int i = 0; i < N_SYM - 1; i++) stim_add(8'h00, 1'b0);
    stim_add(8'h05, 1'b1);
    drive_block();
    checks += 2;
    if (dut_mat !== {12{8'h05}}) begin errors++; $display("FAIL deg0_matrix: got=%h exp=%h", dut_mat, {12{8'h05}}); end
    if (bus.syn_zero !== 1'b0) begin errors++; $display("FAIL deg0_syn_zero: got=%b exp=0", bus.syn_zero); end
    wait_drain();
  endtask

  task automatic test_impulse_deg1();
    stim_clear();
    for (int i = 0; i < N_SYM - 2; i++) stim_add(8'h00, 1'b0);
    stim_add(8'h01, 1'b0);
    stim_add(8'h00, 1'b1);
    drive_block();
    checks++;
    if (dut_mat !== 96'h020408_040810_081020_102040) begin
      errors++;
      $display("FAIL deg1_matrix: got=%h exp=%h", dut_mat, 96'h020408_040810_081020_102040);
    end
    wait_drain();
  endtask

  task automatic test_len_err();
    stim_random(10, 1'b1);
    drive_block();
    checks++;
    if (bus.len_err !== 1'b1) begin errors++; $display("FAIL short_len_err: got=%b exp=1", bus.len_err); end
    wait_drain();
    stim_random(N_SYM, 1'b0);
    drive_block();
    checks++;
    if (bus.len_err !== 1'b1) begin errors++; $display("FAIL nolast_len_err: got=%b exp=1", bus.len_err); end
    wait_drain();
  endtask

  task automatic test_hold_backpressure();
    bus.out_ready = 1'b0;
    stim_random(N_SYM, 1'b1);
    drive_block();
    bus.in_valid = 1'b1;
    bus.in_sym   = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks += 3;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: cyc=%0d got=%b exp=0", c, bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid: cyc=%0d got=%b exp=1", c, bus.out_valid); end
      if (dut_mat !== mat_of(sb_q[0])) begin
        errors++;
        $display("FAIL hold_matrix: cyc=%0d got=%h exp=%h", c, dut_mat, mat_of(sb_q[0]));
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got=%b exp=0", bus.out_valid); end
    stim_random(N_SYM, 1'b1);
    drive_block();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      stim_random(N_SYM, 1'b1);
      drive_block();
      wait_drain();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sym   = 8'($urandom_range(1, 255));
      bus.in_last  = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.syn_zero !== 1'b1) begin errors++; $display("FAIL midrst_syn_zero: got=%b exp=1", bus.syn_zero); end
    if (dut_mat !== 96'h0) begin errors++; $display("FAIL midrst_matrix: got=%h exp=0", dut_mat); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    stim_clear();
    for (int i = 0; i < N_SYM - 1; i++) stim_add(8'h00, 1'b0);
    stim_add(8'h05, 1'b1);
    drive_block();
    checks++;
    if (dut_mat !== {12{8'h05}}) begin errors++; $display("FAIL midrst_result: got=%h exp=%h", dut_mat, {12{8'h05}}); end
    wait_drain();
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_zero_block();
        test_impulse_deg0();
        test_impulse_deg1();
        test_len_err();
        test_hold_backpressure();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL leftover: pending=%0d exp=0", sb_q.size()); end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output: got out_valid=1 with no expected block");
            end else begin
              mon_e = sb_q.pop_front();
              checks += 3;
              if (dut_mat !== mat_of(mon_e)) begin
                errors++;
                $display("FAIL sb_matrix: got=%h exp=%h", dut_mat, mat_of(mon_e));
              end
              if (bus.syn_zero !== mon_e.zero) begin
                errors++;
                $display("FAIL sb_syn_zero: got=%b exp=%b", bus.syn_zero, mon_e.zero);
              end
              if (bus.len_err !== mon_e.len_err) begin
                errors++;
                $display("FAIL sb_len_err: got=%b exp=%b", bus.len_err, mon_e.len_err);
              end
            end
          end
        end
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rs_syndrome_hankel.md
Name: rs_syndrome_hankel

Overview:
- Upstream stage of the 3x3 GF(2^8) determinant block in the RS (t=3) Peterson decoder.
- Accepts a received codeword one symbol per cycle and evaluates the six syndromes S1..S6 by Horner's rule.
- Presents the 3x3 syndrome (Hankel) matrix as d1..d9, plus the right-hand column S4..S6, with a valid/ready handshake.
- Flags an all-zero syndrome (no error) and codeword length violations.

Parameters:
- N_SYM, 15, codeword length in symbols (2..255).
- CNT_W, 8, symbol counter width; must satisfy 2^CNT_W > N_SYM.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_sym  input  8  received symbol, highest-degree coefficient first.
- in_valid  input  1  in_sym valid.
- in_last  input  1  marks the final symbol of the codeword.
- in_ready  output  1  block can accept a symbol.
- d1..d9  output  8 each  Hankel matrix, row-major: S1 S2 S3 / S2 S3 S4 / S3 S4 S5.
- rhs1, rhs2, rhs3  output  8 each  S4, S5, S6.
- syn_zero  output  1  S1..S6 all zero.
- len_err  output  1  codeword length did not equal N_SYM.
- out_valid  output  1  matrix outputs valid.
- out_ready  input  1  downstream consumes the matrix.

Behaviour:
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
- Constant multipliers: alpha^1..alpha^6 = 02, 04, 08, 10, 20, 40.
- Addition is XOR.
- Reset: state=IDLE, S1..S6=0, count=0, out_valid=0, len_err=0, in_ready=1.
  - All d*/rhs* therefore read 0 and syn_zero reads 1.
- States:
  - IDLE (waiting for first symbol).
  - ACCUM (mid-codeword).
  - HOLD (result presented).
- Accept: a symbol is accepted when in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- IDLE, on accept:
  - S_j <= in_sym for all j (the accumulator restarts, so old values are not folded in); count <= 1.
  - Go to ACCUM, unless the block-end condition below holds.
- ACCUM, on accept:
  - S_j <= gf_mul(S_j, alpha^j) XOR in_sym; count <= count+1.
- No accept (in_valid low): registers hold and there is no timeout.
- Block end: occurs on the accepted symbol where in_last=1 or where count+1 == N_SYM, whichever comes first.
  - Next cycle: state=HOLD, out_valid=1.
  - len_err = 1 if (in_last && count+1 != N_SYM) or (count+1 == N_SYM && !in_last); otherwise 0.
- Latency: the results are valid in the cycle after the final symbol is accepted.
- HOLD:
  - S_j, len_err and all outputs are stable.
  - When out_valid && out_ready: next cycle state=IDLE, out_valid=0, count=0, in_ready=1. S_j keep their values until the next first symbol.
  - A new codeword cannot overlap HOLD; there is one bubble minimum between blocks.
- Output mapping:
  - d1..d9 and rhs* are combinational from the S registers.
  - syn_zero = NOR of all S bits. It is only meaningful while out_valid=1.
- Reset asserted mid-codeword or during HOLD: immediate return to the reset values; the partial block is discarded.
- An N_SYM=1 style degenerate case is excluded (minimum 2).

Test Plan:
- Reset, then 15 symbols of 0x00 with in_last on the 15th -> one cycle later: out_valid=1, all d*/rhs*=0x00, syn_zero=1, len_err=0.
- 14 zeros then 0x05 with last -> d1..d9=0x05, rhs1..3=0x05, syn_zero=0, len_err=0.
- 13 zeros, 0x01, 0x00 (last) -> d1..d9 = 02 04 08 04 08 10 08 10 20, rhs = 10 20 40.
- in_last on the 10th symbol (N_SYM=15) -> out_valid next cycle, len_err=1. Separately: 15 symbols with no in_last -> block ends at the 15th, len_err=1.
- Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable throughout. Then out_ready=1 for one cycle -> out_valid=0 next cycle, and the next codeword's results are correct with no residue from the prior block.
- Assert rst_n=0 after 7 symbols, release, send a full 0x05-at-degree-0 codeword -> same result as scenario 2.
